// File: rtl/loader_pkg.sv
// Shared sizing helpers for the pixel loader and the network it feeds.
package loader_pkg;

    function automatic int sweep_len(input int width, input int height);
        return (1 << $clog2(height)) * ((1 << (width + 1)) + 2);
    endfunction

    function automatic int bal_width(input int width, input int height);
        return $clog2(height * ((1 << width) - 1) + 1);
    endfunction

    function automatic int nwords(input int height, input int word);
        return (height + word - 1) / word;
    endfunction

    // Index width that stays legal when only one entry exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_loader_sweep_counter.sv
// Free-running sweep position counter, aligned to the network's own sweep.
module sweep_counter
    import loader_pkg::*;
#(
    parameter int SWEEP = 4112,
    localparam int CW = idx_width(SWEEP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          boundary,
    output logic [CW-1:0] scnt
);

    logic [CW-1:0] scnt_q, scnt_d;

    assign boundary = (scnt_q == CW'(SWEEP - 1));
    assign scnt     = scnt_q;

    always_comb begin
        scnt_d = boundary ? '0 : scnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) scnt_q <= '0;
        else      scnt_q <= scnt_d;
    end

endmodule

// File: rtl/pixel_loader.sv
// Double-buffered frame loader: host words fill a shadow frame that is
// swapped onto pixels at sweep boundaries; each sweep's result goes back.
module pixel_loader
    import loader_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 7,
    parameter int WORD   = 8,
    localparam int NWORDS = nwords(HEIGHT, WORD),
    localparam int SWEEP  = sweep_len(WIDTH, HEIGHT),
    localparam int BAL_W  = bal_width(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD-1:0]   in_data,
    output logic [HEIGHT-1:0] pixels,
    input  logic              neuron_in,
    input  logic [BAL_W-1:0]  balance_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_neuron,
    output logic [BAL_W-1:0]  res_balance,
    output logic              overflow
);

    localparam int WIDX_W = idx_width(NWORDS);
    localparam int CW     = idx_width(SWEEP);

    logic                   boundary;
    logic [CW-1:0]          scnt;
    logic                   accept;

    logic [NWORDS*WORD-1:0] shadow_q, shadow_d;
    logic [WIDX_W-1:0]      widx_q, widx_d;
    logic                   pending_q, pending_d;
    logic                   tagged_q, tagged_d;
    logic [HEIGHT-1:0]      pixels_q, pixels_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_neuron_q, res_neuron_d;
    logic [BAL_W-1:0]       res_bal_q, res_bal_d;
    logic                   ovf_q, ovf_d;

    sweep_counter #(.SWEEP(SWEEP)) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .boundary (boundary),
        .scnt     (scnt)
    );

    assign accept      = in_valid && !pending_q;
    assign in_ready    = !pending_q;
    assign pixels      = pixels_q;
    assign res_valid   = res_valid_q;
    assign res_neuron  = res_neuron_q;
    assign res_balance = res_bal_q;
    assign overflow    = ovf_q;

    always_comb begin
        shadow_d     = shadow_q;
        widx_d       = widx_q;
        pending_d    = pending_q;
        tagged_d     = tagged_q;
        pixels_d     = pixels_q;
        res_valid_d  = res_valid_q;
        res_neuron_d = res_neuron_q;
        res_bal_d    = res_bal_q;
        ovf_d        = ovf_q;

        if (accept) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (widx_q == WIDX_W'(i)) shadow_d[i*WORD +: WORD] = in_data;
            end
            if (widx_q == WIDX_W'(NWORDS - 1)) begin
                widx_d    = '0;
                pending_d = 1'b1;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end

        if (res_valid_q && res_ready) res_valid_d = 1'b0;

        // A capture wins over a same-edge read; an unread result is lost.
        if (boundary && tagged_q) begin
            res_valid_d  = 1'b1;
            res_neuron_d = neuron_in;
            res_bal_d    = balance_in;
            if (res_valid_q && !res_ready) ovf_d = 1'b1;
        end

        if (boundary) begin
            if (pending_q) begin
                pixels_d  = shadow_q[HEIGHT-1:0];
                tagged_d  = 1'b1;
                pending_d = 1'b0;
            end else begin
                pixels_d = '0;
                tagged_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q     <= '0;
            widx_q       <= '0;
            pending_q    <= 1'b0;
            tagged_q     <= 1'b0;
            pixels_q     <= '0;
            res_valid_q  <= 1'b0;
            res_neuron_q <= 1'b0;
            res_bal_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            widx_q       <= widx_d;
            pending_q    <= pending_d;
            tagged_q     <= tagged_d;
            pixels_q     <= pixels_d;
            res_valid_q  <= res_valid_d;
            res_neuron_q <= res_neuron_d;
            res_bal_q    <= res_bal_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader at WIDTH=2, HEIGHT=7, WORD=8 (80-cycle sweep).
module tb_pixel_loader;
    import loader_pkg::*;

    localparam int W     = 2;
    localparam int H     = 7;
    localparam int WD    = 8;
    localparam int BAL_W = bal_width(W, H);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WD-1:0]    in_data = '0;
    logic [H-1:0]     pixels;
    logic             neuron_in = 1'b0;
    logic [BAL_W-1:0] balance_in = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             res_neuron;
    logic [BAL_W-1:0] res_balance;
    logic             overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int seen;

    pixel_loader #(.WIDTH(W), .HEIGHT(H), .WORD(WD)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .pixels      (pixels),
        .neuron_in   (neuron_in),
        .balance_in  (balance_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_neuron  (res_neuron),
        .res_balance (res_balance),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    // cyc is the index of the next posedge; sampling is 1ns after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #12;
        release_rst();
        #1;
        chk("rst_pixels", 32'(pixels), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_neuron", 32'(res_neuron), 0);
        chk("rst_res_balance", 32'(res_balance), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // idle: 400 cycles without stimulus
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (res_valid || pixels != 0 || !in_ready) seen++;
        end
        chk("idle_quiet", 32'(seen), 0);

        // restart so the directed cycle numbers line up
        @(negedge clk);
        rst = 1'b0;
        release_rst();
        run_to(5);
        in_valid = 1'b1;
        in_data  = 8'h0E;
        step();
        in_valid = 1'b0;
        chk("load_ready_low", 32'(in_ready), 0);
        neuron_in  = 1'b1;
        balance_in = BAL_W'(9);
        run_to(79);
        chk("pre_swap_pixels", 32'(pixels), 0);
        step();
        chk("swap_pixels", 32'(pixels), 32'h0E);
        chk("swap_ready", 32'(in_ready), 1);
        run_to(159);
        chk("pre_res_valid", 32'(res_valid), 0);
        step();
        chk("res_valid", 32'(res_valid), 1);
        chk("res_neuron", 32'(res_neuron), 1);
        chk("res_balance", 32'(res_balance), 9);
        chk("empty_swap_pixels", 32'(pixels), 0);
        step();
        chk("res_held", 32'(res_valid), 1);
        res_ready = 1'b1;
        step();
        chk("res_consumed", 32'(res_valid), 0);
        chk("no_overflow", 32'(overflow), 0);

        // last word accepted on the boundary edge itself
        run_to(239);
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        chk("bnd_word_pixels", 32'(pixels), 0);
        chk("bnd_word_pending", 32'(in_ready), 0);
        chk("bnd_untagged", 32'(res_valid), 0);
        run_to(319);
        step();
        chk("bnd_word_swap", 32'(pixels), 32'h55);

        // second frame offered while the first is pending
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        in_data = 8'h7F;
        seen = 0;
        while (cyc < 399) begin
            if (in_ready) seen++;
            step();
        end
        chk("stall_ready", 32'(seen), 0);
        chk("stall_pixels", 32'(pixels), 32'h55);
        step();
        chk("stall_swap", 32'(pixels), 32'h33);
        chk("stall_release", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("stall_accept", 32'(in_ready), 0);
        run_to(480);
        chk("stall_frame2", 32'(pixels), 32'h7F);

        // back-to-back frames with the host always ready
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k + 1);
            step();
            in_valid = 1'b0;
            if (res_valid) seen++;
            balance_in = BAL_W'(k + 2);
            neuron_in  = k[0];
            while (cyc < 560 + 80 * k) begin
                step();
                if (res_valid) seen++;
            end
            chk("stream_balance", 32'(res_balance), 32'(k + 2));
            chk("stream_neuron", 32'(res_neuron), 32'(k % 2));
        end
        chk("stream_results", 32'(seen), 3);
        chk("stream_overflow", 32'(overflow), 0);

        // two results while the host is stalled
        step();
        res_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h0A;
        step();
        in_valid   = 1'b0;
        balance_in = BAL_W'(3);
        run_to(800);
        chk("ovf_first_valid", 32'(res_valid), 1);
        chk("ovf_first_bal", 32'(res_balance), 3);
        chk("ovf_first_flag", 32'(overflow), 0);
        in_valid   = 1'b1;
        in_data    = 8'h11;
        step();
        in_valid   = 1'b0;
        balance_in = BAL_W'(5);
        run_to(880);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_second_bal", 32'(res_balance), 5);
        chk("ovf_pixels", 32'(pixels), 32'h11);

        // reset mid-sweep with a pending frame and an unread result
        in_valid = 1'b1;
        in_data  = 8'h44;
        step();
        in_valid = 1'b0;
        run_to(900);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_pixels", 32'(pixels), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_bal", 32'(res_balance), 0);
        chk("mid_rst_neuron", 32'(res_neuron), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        release_rst();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        in_valid = 1'b0;
        run_to(79);
        chk("post_rst_hold", 32'(pixels), 0);
        step();
        chk("post_rst_swap", 32'(pixels), 32'h2A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
